// File: rtl/ex_operand_stage.sv
// Registered operand-select stage between ID and the EX-stage ALU.
// Resolves rj/rk through prioritised forwarding, extends the immediate and interlocks on pending producers.
module ex_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 26,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [7:0]                op,
    input  logic [3:0]                op_type,
    input  logic [4:0]                rj_idx,
    input  logic [4:0]                rk_idx,
    input  logic [DATA_W-1:0]         rj_rf,
    input  logic [DATA_W-1:0]         rk_rf,
    input  logic [IMM_W-1:0]          imm_unext,
    input  logic [2:0]                imm_sz,
    input  logic [4:0]                shift_imm,
    input  logic                      flag_unsigned,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*5-1:0]      fwd_idx,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [DATA_W-1:0]         alu_in1,
    output logic [DATA_W-1:0]         alu_in2,
    output logic [7:0]                ex_op,
    output logic [3:0]                ex_op_type,
    output logic [CNT_W-1:0]          stall_cnt
);
    localparam logic [3:0] OP_TYPE_3R = 4'd1;
    localparam logic [7:0] OP_SLLI    = 8'h10;
    localparam logic [7:0] OP_SRLI    = 8'h11;
    localparam logic [7:0] OP_SRAI    = 8'h12;
    localparam logic [2:0] IMM_SZ_8   = 3'd1;
    localparam logic [2:0] IMM_SZ_12  = 3'd2;
    localparam logic [2:0] IMM_SZ_14  = 3'd3;
    localparam logic [2:0] IMM_SZ_16  = 3'd4;
    localparam logic [2:0] IMM_SZ_20  = 3'd5;
    localparam logic [2:0] IMM_SZ_26  = 3'd6;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_WAIT = 2'd1, ST_VALID = 2'd2} state_t;

    // Returns {hazard, value}; the lowest-numbered matching channel wins.
    function automatic logic [DATA_W:0] resolve_src(
        input logic [4:0]                idx,
        input logic [DATA_W-1:0]         rf_val,
        input logic [NUM_FWD-1:0]        fv,
        input logic [NUM_FWD-1:0]        fp,
        input logic [NUM_FWD*5-1:0]      fi,
        input logic [NUM_FWD*DATA_W-1:0] fd
    );
        logic [DATA_W:0] res;
        res = {1'b0, rf_val};
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            res = (fv[i] && (fi[i*5 +: 5] == idx)) ? {fp[i], fd[i*DATA_W +: DATA_W]} : res;
        end
        return (idx == 5'd0) ? {(DATA_W+1){1'b0}} : res;
    endfunction

    function automatic logic [DATA_W-1:0] imm_extend(
        input logic [IMM_W-1:0] imm,
        input logic [2:0]       sz,
        input logic             uns
    );
        logic [DATA_W-1:0] res;
        res = {DATA_W{1'b0}};
        case (sz)
            IMM_SZ_8:  begin res = {DATA_W{imm[7]}};         res[7:0]  = imm[7:0];  end
            IMM_SZ_12: begin res = {DATA_W{imm[11] & ~uns}}; res[11:0] = imm[11:0]; end
            IMM_SZ_14: begin res = {DATA_W{imm[13]}};        res[13:0] = imm[13:0]; end
            IMM_SZ_16: begin res = {DATA_W{imm[15]}};        res[15:0] = imm[15:0]; end
            IMM_SZ_20: begin res = {DATA_W{imm[19]}};        res[31:0] = {imm[19:0], 12'h000}; end
            IMM_SZ_26: begin res = {DATA_W{imm[25]}};        res[25:0] = imm[25:0]; end
            default:   res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    state_t             state_r, state_s;
    logic               ex_valid_r, valid_s, load_s, capture_s;
    logic [DATA_W-1:0]  alu_in1_r, alu_in2_r, in2_s;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [7:0]         op_r, sel_op_s;
    logic [3:0]         op_type_r, sel_op_type_s;
    logic [4:0]         rj_idx_r, rk_idx_r, shift_r, sel_rj_idx_s, sel_rk_idx_s, sel_shift_s;
    logic [DATA_W-1:0]  rj_rf_r, rk_rf_r, sel_rj_rf_s, sel_rk_rf_s;
    logic [IMM_W-1:0]   imm_r, sel_imm_s;
    logic [2:0]         imm_sz_r, sel_imm_sz_s;
    logic               uns_r, sel_uns_s;
    logic [DATA_W:0]    rj_res_s, rk_res_s;
    logic               is_shift_s, rk_need_s, hazard_s;

    assign id_ready   = !flush && ((state_r == ST_EMPTY) || ((state_r == ST_VALID) && ex_ready));
    assign capture_s  = id_valid && id_ready;
    assign ex_valid   = ex_valid_r;
    assign alu_in1    = alu_in1_r;
    assign alu_in2    = alu_in2_r;
    assign ex_op      = op_r;
    assign ex_op_type = op_type_r;
    assign stall_cnt  = stall_cnt_r;

    // While waiting, resolution runs on the latched copy; otherwise on the incoming ID fields.
    always_comb begin
        if (state_r == ST_WAIT) begin
            sel_op_s = op_r;         sel_op_type_s = op_type_r;
            sel_rj_idx_s = rj_idx_r; sel_rk_idx_s  = rk_idx_r;
            sel_rj_rf_s = rj_rf_r;   sel_rk_rf_s   = rk_rf_r;
            sel_imm_s = imm_r;       sel_imm_sz_s  = imm_sz_r;
            sel_shift_s = shift_r;   sel_uns_s     = uns_r;
        end else begin
            sel_op_s = op;           sel_op_type_s = op_type;
            sel_rj_idx_s = rj_idx;   sel_rk_idx_s  = rk_idx;
            sel_rj_rf_s = rj_rf;     sel_rk_rf_s   = rk_rf;
            sel_imm_s = imm_unext;   sel_imm_sz_s  = imm_sz;
            sel_shift_s = shift_imm; sel_uns_s     = flag_unsigned;
        end
    end

    // Operand resolution, hazard detection and second-operand selection.
    always_comb begin
        rj_res_s   = resolve_src(sel_rj_idx_s, sel_rj_rf_s, fwd_valid, fwd_pending, fwd_idx, fwd_data);
        rk_res_s   = resolve_src(sel_rk_idx_s, sel_rk_rf_s, fwd_valid, fwd_pending, fwd_idx, fwd_data);
        is_shift_s = (sel_op_s == OP_SLLI) || (sel_op_s == OP_SRAI) || (sel_op_s == OP_SRLI);
        rk_need_s  = (sel_op_type_s == OP_TYPE_3R) && !is_shift_s;
        hazard_s   = rj_res_s[DATA_W] || (rk_need_s && rk_res_s[DATA_W]);
        in2_s      = imm_extend(sel_imm_s, sel_imm_sz_s, sel_uns_s);
        if (sel_op_type_s == OP_TYPE_3R) begin
            in2_s = is_shift_s ? {{(DATA_W-5){1'b0}}, sel_shift_s} : rk_res_s[DATA_W-1:0];
        end else begin
            in2_s = imm_extend(sel_imm_s, sel_imm_sz_s, sel_uns_s);
        end
    end

    // Next-state and operand-load decisions; flush overrides everything.
    always_comb begin
        state_s = state_r;
        valid_s = ex_valid_r;
        load_s  = 1'b0;
        if (flush) begin
            state_s = ST_EMPTY;
            valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY, ST_VALID: begin
                    if (capture_s && hazard_s) begin
                        state_s = ST_WAIT;
                        valid_s = 1'b0;
                    end else if (capture_s) begin
                        state_s = ST_VALID;
                        valid_s = 1'b1;
                        load_s  = 1'b1;
                    end else if ((state_r == ST_VALID) && ex_ready) begin
                        state_s = ST_EMPTY;
                        valid_s = 1'b0;
                    end else begin
                        state_s = state_r;
                        valid_s = ex_valid_r;
                    end
                end
                ST_WAIT: begin
                    if (hazard_s) begin
                        state_s = ST_WAIT;
                        valid_s = 1'b0;
                    end else begin
                        state_s = ST_VALID;
                        valid_s = 1'b1;
                        load_s  = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State register and registered ALU operands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_EMPTY;
            ex_valid_r <= 1'b0;
            alu_in1_r  <= {DATA_W{1'b0}};
            alu_in2_r  <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_s;
            ex_valid_r <= valid_s;
            if (load_s) begin
                alu_in1_r <= rj_res_s[DATA_W-1:0];
                alu_in2_r <= in2_s;
            end
        end
    end

    // Hold registers for the captured instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r <= 8'h00;               op_type_r <= 4'h0;
            rj_idx_r <= 5'd0;            rk_idx_r  <= 5'd0;
            rj_rf_r <= {DATA_W{1'b0}};   rk_rf_r   <= {DATA_W{1'b0}};
            imm_r <= {IMM_W{1'b0}};      imm_sz_r  <= 3'd0;
            shift_r <= 5'd0;             uns_r     <= 1'b0;
        end else if (capture_s) begin
            op_r <= op;                  op_type_r <= op_type;
            rj_idx_r <= rj_idx;          rk_idx_r  <= rk_idx;
            rj_rf_r <= rj_rf;            rk_rf_r   <= rk_rf;
            imm_r <= imm_unext;          imm_sz_r  <= imm_sz;
            shift_r <= shift_imm;        uns_r     <= flag_unsigned;
        end
    end

    // Saturating count of interlock cycles; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_ex_operand_stage;
    localparam logic [3:0] OT_3R    = 4'd1;
    localparam logic [3:0] OT_2RI12 = 4'd2;
    localparam logic [3:0] OT_1RI20 = 4'd3;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_ADDI  = 8'h02;
    localparam logic [7:0] OP_LU12I = 8'h03;
    localparam logic [7:0] OP_SLLI  = 8'h10;
    localparam logic [7:0] OP_SRLI  = 8'h11;
    localparam logic [7:0] OP_SRAI  = 8'h12;

    logic        clk = 1'b0;
    logic        resetn, flush, id_valid, id_ready, flag_unsigned, ex_valid, ex_ready;
    logic [7:0]  op, ex_op;
    logic [3:0]  op_type, ex_op_type;
    logic [4:0]  rj_idx, rk_idx, shift_imm;
    logic [31:0] rj_rf, rk_rf, alu_in1, alu_in2;
    logic [25:0] imm_unext;
    logic [2:0]  imm_sz;
    logic [1:0]  fwd_valid, fwd_pending;
    logic [9:0]  fwd_idx;
    logic [63:0] fwd_data;
    logic [15:0] stall_cnt;

    int n_run = 0;
    int n_fail = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .resetn(resetn), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .op(op), .op_type(op_type), .rj_idx(rj_idx), .rk_idx(rk_idx), .rj_rf(rj_rf), .rk_rf(rk_rf),
        .imm_unext(imm_unext), .imm_sz(imm_sz), .shift_imm(shift_imm), .flag_unsigned(flag_unsigned),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .ex_op(ex_op), .ex_op_type(ex_op_type), .stall_cnt(stall_cnt)
    );

    // ---------------- reference model ----------------
    function automatic longint sext(input longint v, input int bits);
        longint h;
        h = longint'(1) << (bits - 1);
        return (v ^ h) - h;
    endfunction

    function automatic logic [31:0] m_imm(input logic [25:0] imm, input logic [2:0] sz, input logic uns);
        longint v;
        case (sz)
            3'd1:    v = sext(longint'(imm[7:0]), 8);
            3'd2:    v = uns ? longint'(imm[11:0]) : sext(longint'(imm[11:0]), 12);
            3'd3:    v = sext(longint'(imm[13:0]), 14);
            3'd4:    v = sext(longint'(imm[15:0]), 16);
            3'd5:    v = sext(longint'(imm[19:0]), 20) * 4096;
            3'd6:    v = sext(longint'(imm), 26);
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic bit m_is_shift(input logic [7:0] o);
        return (o == OP_SLLI) || (o == OP_SRLI) || (o == OP_SRAI);
    endfunction

    // {hazard, value} for a source given the forwarding inputs currently driven
    function automatic logic [32:0] m_src(input logic [4:0] x, input logic [31:0] rf);
        if (x == 5'd0) return 33'd0;
        for (int i = 0; i < 2; i++) begin
            if (fwd_valid[i] && fwd_idx[i*5 +: 5] == x) return {fwd_pending[i], fwd_data[i*32 +: 32]};
        end
        return {1'b0, rf};
    endfunction

    function automatic logic [31:0] m_in2(input logic [7:0] o, input logic [3:0] t, input logic [31:0] rkv,
                                          input logic [4:0] sh, input logic [25:0] im, input logic [2:0] sz,
                                          input logic u);
        if (t != OT_3R) return m_imm(im, sz, u);
        if (m_is_shift(o)) return 32'(sh);
        return rkv;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        op = 8'h00; op_type = 4'h0; rj_idx = 5'd0; rk_idx = 5'd0; rj_rf = 32'h0; rk_rf = 32'h0;
        imm_unext = 26'h0; imm_sz = 3'd0; shift_imm = 5'd0; flag_unsigned = 1'b0;
        fwd_valid = 2'b00; fwd_pending = 2'b00; fwd_idx = 10'h0; fwd_data = 64'h0;
    endtask

    task automatic set_instr(input logic [7:0] o, input logic [3:0] t, input logic [4:0] j, input logic [4:0] k,
                             input logic [31:0] jv, input logic [31:0] kv, input logic [25:0] im,
                             input logic [2:0] sz, input logic [4:0] sh, input logic u);
        op = o; op_type = t; rj_idx = j; rk_idx = k; rj_rf = jv; rk_rf = kv;
        imm_unext = im; imm_sz = sz; shift_imm = sh; flag_unsigned = u;
    endtask

    task automatic set_fwd(input int ch, input logic v, input logic p, input logic [4:0] idx, input logic [31:0] d);
        fwd_valid[ch] = v;
        fwd_pending[ch] = p;
        fwd_idx[ch*5 +: 5] = idx;
        fwd_data[ch*32 +: 32] = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        #2;
        n_run++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
        n_run++; if (alu_in1 !== 32'h0) begin n_fail++; $display("FAIL reset_alu_in1: got %h expected 0", alu_in1); end
        n_run++; if (alu_in2 !== 32'h0) begin n_fail++; $display("FAIL reset_alu_in2: got %h expected 0", alu_in2); end
        n_run++; if (ex_op !== 8'h0 || ex_op_type !== 4'h0) begin n_fail++; $display("FAIL reset_ex_op: got %h/%h expected 0/0", ex_op, ex_op_type); end
        n_run++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        n_run++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready: got %b expected 1", id_ready); end
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        set_instr(OP_ADDI, OT_2RI12, 5'd4, 5'd0, 32'h10, 32'h0, 26'hFFF, 3'd2, 5'd0, 1'b0);
        id_valid = 1'b1;
        #1;
        n_run++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL addi_id_ready: got %b expected 1", id_ready); end
        tick();
        n_run++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL addi_ex_valid: got %b expected 1", ex_valid); end
        n_run++; if (alu_in1 !== 32'h10) begin n_fail++; $display("FAIL addi_in1: got %h expected 00000010", alu_in1); end
        n_run++; if (alu_in2 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_sext_in2: got %h expected ffffffff", alu_in2); end
        n_run++; if (ex_op !== OP_ADDI) begin n_fail++; $display("FAIL addi_ex_op: got %h expected %h", ex_op, OP_ADDI); end
        flag_unsigned = 1'b1;
        tick();
        n_run++; if (ex_valid !== 1'b1 || alu_in2 !== 32'h00000FFF) begin n_fail++; $display("FAIL addi_zext_in2: got v=%b %h expected v=1 00000fff", ex_valid, alu_in2); end
        id_valid = 1'b0;
        tick();
        n_run++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b expected 0", ex_valid); end
        idle_inputs();
    endtask

    task automatic test_fwd_priority();
        set_instr(OP_ADD, OT_3R, 5'd1, 5'd5, 32'h5, 32'h99, 26'h0, 3'd0, 5'd0, 1'b0);
        set_fwd(1, 1'b1, 1'b0, 5'd5, 32'h22);
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h11);
        id_valid = 1'b1;
        tick();
        n_run++; if (alu_in2 !== 32'h11 || alu_in1 !== 32'h5) begin n_fail++; $display("FAIL fwd_priority: got in1=%h in2=%h expected 5/11", alu_in1, alu_in2); end
        rk_idx = 5'd0;
        set_fwd(0, 1'b1, 1'b0, 5'd0, 32'h55);
        tick();
        n_run++; if (ex_valid !== 1'b1 || alu_in2 !== 32'h0) begin n_fail++; $display("FAIL fwd_r0: got v=%b in2=%h expected v=1 0", ex_valid, alu_in2); end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        set_instr(OP_ADDI, OT_2RI12, 5'd7, 5'd0, 32'h777, 32'h0, 26'h123, 3'd2, 5'd0, 1'b0);
        set_fwd(0, 1'b1, 1'b1, 5'd7, 32'hDEAD);
        id_valid = 1'b1;
        #1;
        n_run++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_capture_ready: got %b expected 1", id_ready); end
        tick();
        id_valid = 1'b0; imm_unext = 26'h0; rj_rf = 32'h0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_run++; if (id_ready !== 1'b0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_wait_%0d: got rdy=%b v=%b expected 0/0", c, id_ready, ex_valid); end
            tick();
            exp_stall++;
        end
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'hABCD);
        #1;
        n_run++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_wait_last: got %b expected 0", id_ready); end
        tick();
        exp_stall++;
        n_run++; if (ex_valid !== 1'b1 || alu_in1 !== 32'hABCD) begin n_fail++; $display("FAIL lu_resolve: got v=%b in1=%h expected v=1 0000abcd", ex_valid, alu_in1); end
        n_run++; if (alu_in2 !== 32'h123) begin n_fail++; $display("FAIL lu_latched_imm: got %h expected 00000123", alu_in2); end
        n_run++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
        ex_ready = 1'b0;
        set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h5555);
        set_instr(OP_ADD, OT_3R, 5'd2, 5'd3, 32'h1, 32'h2, 26'h0, 3'd0, 5'd0, 1'b0);
        id_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_run++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL hold_id_ready_%0d: got %b expected 0", c, id_ready); end
            tick();
            n_run++; if (ex_valid !== 1'b1 || alu_in1 !== 32'hABCD || alu_in2 !== 32'h123 || ex_op !== OP_ADDI)
                begin n_fail++; $display("FAIL hold_stable_%0d: got v=%b %h %h op=%h expected v=1 0000abcd 00000123 op=02", c, ex_valid, alu_in1, alu_in2, ex_op); end
        end
        id_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        n_run++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_drain: got %b expected 0", ex_valid); end
        idle_inputs();
    endtask

    task automatic test_shift_imm();
        set_instr(OP_SLLI, OT_3R, 5'd3, 5'd9, 32'h30, 32'h99, 26'h0, 3'd0, 5'd7, 1'b0);
        set_fwd(0, 1'b1, 1'b1, 5'd9, 32'hBAD);
        id_valid = 1'b1;
        #1;
        n_run++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL slli_ready: got %b expected 1", id_ready); end
        tick();
        n_run++; if (ex_valid !== 1'b1 || alu_in2 !== 32'h7 || alu_in1 !== 32'h30) begin n_fail++; $display("FAIL slli_no_stall: got v=%b in1=%h in2=%h expected v=1 30 7", ex_valid, alu_in1, alu_in2); end
        n_run++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL slli_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
        idle_inputs();
        tick();
    endtask

    task automatic test_imm_sizes();
        logic [2:0]  szs [9] = '{3'd5, 3'd6, 3'd1, 3'd3, 3'd4, 3'd4, 3'd2, 3'd0, 3'd7};
        logic [25:0] imms[9] = '{26'h80000, 26'h2000000, 26'h180, 26'h2000, 26'h7FFF, 26'h18000, 26'h800, 26'h3FFFFFF, 26'h3FFFFFF};
        logic        unss[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exps[9] = '{32'h80000000, 32'hFE000000, 32'hFFFFFF80, 32'hFFFFE000, 32'h00007FFF,
                                 32'hFFFF8000, 32'h00000800, 32'h0, 32'h0};
        id_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_instr(OP_LU12I, OT_1RI20, 5'd0, 5'd0, 32'h0, 32'h0, imms[i], szs[i], 5'd0, unss[i]);
            tick();
            n_run++; if (ex_valid !== 1'b1 || alu_in2 !== exps[i]) begin n_fail++; $display("FAIL imm_sz_%0d: got v=%b %h expected v=1 %h", szs[i], ex_valid, alu_in2, exps[i]); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_wait();
        set_instr(OP_ADD, OT_3R, 5'd2, 5'd6, 32'h1, 32'h2, 26'h0, 3'd0, 5'd0, 1'b0);
        set_fwd(1, 1'b1, 1'b1, 5'd6, 32'h0);
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
        flush = 1'b1;
        #1;
        n_run++; if (id_ready !== 1'b0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_in_wait: got rdy=%b v=%b expected 0/0", id_ready, ex_valid); end
        tick();
        exp_stall++;
        flush = 1'b0;
        set_fwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        n_run++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got v=%b rdy=%b expected 0/1", ex_valid, id_ready); end
        n_run++; if (stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL flush_keeps_stall: got %0d expected %0d", stall_cnt, exp_stall); end
        tick();
        n_run++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_resume: got %b expected 0", ex_valid); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        set_instr(OP_ADDI, OT_2RI12, 5'd8, 5'd0, 32'h8, 32'h0, 26'h5, 3'd2, 5'd0, 1'b0);
        set_fwd(1, 1'b1, 1'b1, 5'd8, 32'h0);
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        n_run++; if (ex_valid !== 1'b0 || alu_in1 !== 32'h0 || alu_in2 !== 32'h0 || ex_op !== 8'h0 || ex_op_type !== 4'h0 || stall_cnt !== 16'h0)
            begin n_fail++; $display("FAIL reset_mid_wait: got v=%b %h %h %h %h %0d expected all zero", ex_valid, alu_in1, alu_in2, ex_op, ex_op_type, stall_cnt); end
        exp_stall = 0;
        idle_inputs();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_random(input int n);
        logic [7:0]  s_op;
        logic [3:0]  s_ot;
        logic [4:0]  s_rj, s_rk, s_sh;
        logic [31:0] s_rjv, s_rkv, e1, e2;
        logic [25:0] s_im;
        logic [2:0]  s_sz;
        logic        s_u, haz;
        logic [32:0] r1, r2;
        int          k;
        for (int it = 0; it < n; it++) begin
            case ($urandom_range(0, 5))
                0: s_op = OP_ADD;   1: s_op = OP_ADDI;  2: s_op = OP_LU12I;
                3: s_op = OP_SLLI;  4: s_op = OP_SRLI;  default: s_op = OP_SRAI;
            endcase
            s_ot = ($urandom_range(0, 2) == 0) ? OT_2RI12 : (($urandom_range(0, 1) == 0) ? OT_1RI20 : OT_3R);
            s_rj = 5'($urandom_range(0, 7)); s_rk = 5'($urandom_range(0, 7));
            s_rjv = $urandom; s_rkv = $urandom; s_im = 26'($urandom); s_sz = 3'($urandom_range(0, 7));
            s_sh = 5'($urandom); s_u = 1'($urandom);
            set_instr(s_op, s_ot, s_rj, s_rk, s_rjv, s_rkv, s_im, s_sz, s_sh, s_u);
            for (int c = 0; c < 2; c++) set_fwd(c, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            id_valid = 1'b1;
            ex_ready = 1'b1;
            #1;
            n_run++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready_%0d: got %b expected 1", it, id_ready); end
            r1 = m_src(s_rj, s_rjv);
            r2 = m_src(s_rk, s_rkv);
            haz = r1[32] || ((s_ot == OT_3R) && !m_is_shift(s_op) && r2[32]);
            tick();
            id_valid = 1'b0; rj_rf = $urandom; rk_rf = $urandom; imm_unext = 26'($urandom); op = 8'($urandom); shift_imm = 5'($urandom);
            if (haz) begin
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) begin
                    #1;
                    n_run++; if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_wait_%0d: got v=%b rdy=%b expected 0/0", it, ex_valid, id_ready); end
                    tick();
                    exp_stall++;
                end
                fwd_pending = 2'b00;
                fwd_data = {$urandom, $urandom};
                r1 = m_src(s_rj, s_rjv);
                r2 = m_src(s_rk, s_rkv);
                tick();
                exp_stall++;
            end
            e1 = r1[31:0];
            e2 = m_in2(s_op, s_ot, r2[31:0], s_sh, s_im, s_sz, s_u);
            n_run++; if (ex_valid !== 1'b1 || alu_in1 !== e1 || alu_in2 !== e2)
                begin n_fail++; $display("FAIL rnd_operands_%0d: got v=%b %h %h expected v=1 %h %h", it, ex_valid, alu_in1, alu_in2, e1, e2); end
            n_run++; if (ex_op !== s_op || ex_op_type !== s_ot || stall_cnt !== 16'(exp_stall))
                begin n_fail++; $display("FAIL rnd_meta_%0d: got op=%h t=%h st=%0d expected op=%h t=%h st=%0d", it, ex_op, ex_op_type, stall_cnt, s_op, s_ot, exp_stall); end
            ex_ready = 1'b0;
            fwd_data = {$urandom, $urandom};
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                tick();
                n_run++; if (ex_valid !== 1'b1 || alu_in1 !== e1 || alu_in2 !== e2) begin n_fail++; $display("FAIL rnd_hold_%0d: got v=%b %h %h expected v=1 %h %h", it, ex_valid, alu_in1, alu_in2, e1, e2); end
            end
            ex_ready = 1'b1;
            tick();
            n_run++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain_%0d: got %b expected 0", it, ex_valid); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_fwd_priority();
        test_load_use();
        test_shift_imm();
        test_imm_sizes();
        test_flush_wait();
        test_reset_mid_wait();
        test_random(150);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Registered, parametrised operand-select stage between ID and the EX-stage ALU; successor to the combinational ALU second-operand mux.
- Resolves rj/rk from NUM_FWD forwarding channels with priority, extends the immediate (adds 16-bit, 20-bit upper and 26-bit modes), and chooses register, shift-immediate or immediate for the second operand.
- Holds the instruction while a needed forwarding source is still pending (load-use interlock).
- Presents alu_in1/alu_in2 downstream under a valid/ready handshake, with flush and a stall counter.

Parameters:
DATA_W, 32, operand width; must be >= 32.
IMM_W, 26, width of imm_unext.
NUM_FWD, 2, forwarding channels; index 0 is the youngest producer and has the highest priority.
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of the held instruction
id_valid  in  1  ID presents an instruction
id_ready  out  1  stage accepts this cycle
op  in  8  opcode, encoded per defs.v
op_type  in  4  instruction format, encoded per defs.v
rj_idx, rk_idx  in  5 each  source register numbers
rj_rf, rk_rf  in  DATA_W each  register-file read data
imm_unext  in  IMM_W  raw immediate
imm_sz  in  3  immediate size code, per defs.v
shift_imm  in  5  shift amount
flag_unsigned  in  1  zero-extend the 12-bit immediate
fwd_valid  in  NUM_FWD  channel holds a register write
fwd_pending  in  NUM_FWD  channel's data is not yet available
fwd_idx  in  NUM_FWD*5  destination register per channel
fwd_data  in  NUM_FWD*DATA_W  data per channel
ex_valid  out  1  operands valid
ex_ready  in  1  ALU consumes this cycle
alu_in1  out  DATA_W  resolved rj
alu_in2  out  DATA_W  selected second operand
ex_op  out  8  registered op
ex_op_type  out  4  registered op_type
stall_cnt  out  CNT_W  saturating count of cycles spent in WAIT

Behaviour:
- Reset (async, resetn=0):
  - State goes to EMPTY.
  - ex_valid=0, alu_in1=0, alu_in2=0, ex_op=0, ex_op_type=0, stall_cnt=0; all latched fields cleared.
- States: EMPTY, WAIT, VALID.
- id_ready is 1 when:
  - state is EMPTY, or
  - state is VALID and ex_ready=1.
  - It is 0 in WAIT and whenever flush=1.
- Capture happens when id_valid && id_ready. All ID fields are latched into hold registers.
- Source resolution, applied to a source s with index x:
  - x=0: value is 0 and never hazards.
  - Otherwise take the lowest channel i with fwd_valid[i] && fwd_idx[i]==x.
    - If fwd_pending[i]=1: hazard.
    - Else: value is fwd_data[i].
  - No matching channel: use the register-file value, from the latched copy when in WAIT.
- rk is needed only when op_type==OP_TYPE_3R and op is not SLLI, SRAI or SRLI. An rk hazard on an instruction that does not need rk is ignored.
- alu_in2 selection:
  - 3R non-shift: rk value.
  - 3R shift-immediate (SLLI/SRAI/SRLI): zero-extended shift_imm.
  - Otherwise: imm_ext.
- imm_ext by imm_sz:
  - IMM_SZ_8: sign-extend bits [7:0].
  - IMM_SZ_12: zero-extend [11:0] if flag_unsigned, else sign-extend.
  - IMM_SZ_14: sign-extend [13:0].
  - IMM_SZ_16: sign-extend [15:0].
  - IMM_SZ_20: {sign-extended [19:0], 12'b0}.
  - IMM_SZ_26: sign-extend [25:0].
  - Any other code: 0.
  - All results are extended to DATA_W.
- Transitions, evaluated in the capture cycle from the incoming fields and the current forwarding inputs:
  - Capture with no hazard: go to VALID; operands registered at that edge; ex_valid=1 the next cycle (1-cycle latency).
  - Capture with a hazard: go to WAIT; ex_valid stays 0.
  - WAIT: re-resolve every cycle from the latched fields. Once no hazard remains, register the operands and go to VALID. stall_cnt increments each WAIT cycle and saturates at all-ones.
  - VALID with ex_ready=1 and a capture: back-to-back; stay VALID with new operands. If the new instruction hazards, go to WAIT.
  - VALID with ex_ready=1 and no capture: go to EMPTY; ex_valid=0.
  - VALID with ex_ready=0: hold all outputs stable.
- flush=1 has priority over everything:
  - Next state is EMPTY, ex_valid=0, no capture that cycle (id_ready is already 0).
  - stall_cnt is not cleared.
- Forwarding data is sampled only on the resolving edge. Later changes do not alter registered operands.

Test Plan:
- Reset, then ADDI with rj=r4 (rf 0x10), imm12=0xFFF, flag_unsigned=0 -> one cycle later ex_valid=1, alu_in1=0x10, alu_in2=0xFFFFFFFF; with flag_unsigned=1 -> alu_in2=0x00000FFF.
- 3R ADD, rk=r5; ch1 has r5=0x22 and ch0 has r5=0x11, both non-pending -> alu_in2=0x11 (ch0 wins); rk_idx=0 with ch0 targeting r0 -> alu_in2=0.
- ch0 targets rj with pending=1 for 3 cycles, then drops pending with data 0xABCD -> id_ready=0 for 3 cycles, stall_cnt=3, then ex_valid=1 with alu_in1=0xABCD.
- SLLI, shift_imm=7, rk_idx matching a pending channel -> no stall; alu_in2=0x7.
- IMM_SZ_20 imm=0x80000 -> alu_in2=0x80000000; IMM_SZ_26 imm=0x2000000 -> alu_in2=0xFE000000.
- ex_ready=0 for 2 cycles in VALID -> outputs stable, id_ready=0; flush asserted during WAIT -> ex_valid stays 0, state EMPTY the next cycle; resetn dropped mid-WAIT -> all outputs 0 immediately.
